// File: rtl/one_four_tdm_demux_if.sv
// Bus bundle for the 1-to-4 TDM demultiplexer: serial input side plus
// the four held channel words, their strobes and alignment status.
interface one_four_tdm_demux_if #(
   parameter int W = 8
);
   logic         en;
   logic         din;
   logic         frame_sync;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] c;
   logic [W-1:0] d;
   logic         va;
   logic         vb;
   logic         vc;
   logic         vd;
   logic [1:0]   s;
   logic         locked;
   logic         sync_err;

   modport master (
      output en, din, frame_sync,
      input  a, b, c, d, va, vb, vc, vd, s, locked, sync_err
   );

   modport slave (
      input  en, din, frame_sync,
      output a, b, c, d, va, vb, vc, vd, s, locked, sync_err
   );
endinterface

// File: rtl/one_four_tdm_demux.sv
// Serial TDM demultiplexer: aligns to frame_sync, assembles W-bit slots
// MSB first and distributes them round-robin into four held channel words.
module one_four_tdm_demux #(
   parameter int W = 8
) (
   input logic                   clk,
   input logic                   rst,
   one_four_tdm_demux_if.slave   bus
);
   localparam int CW = $clog2(W);

   typedef enum logic {HUNT, LOCK} state_t;

   state_t        state, state_n;
   logic [W-1:0]  shift_q, shift_n;
   logic [CW-1:0] bit_cnt, bit_cnt_n;
   logic [1:0]    slot, slot_n;
   logic [W-1:0]  ch_q [4];
   logic [W-1:0]  ch_n [4];
   logic [3:0]    strobe_q, strobe_n;
   logic          err_q, err_n;
   logic [W-1:0]  word_in;
   logic          frame_start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= HUNT;
         shift_q  <= '0;
         bit_cnt  <= '0;
         slot     <= '0;
         ch_q     <= '{default: '0};
         strobe_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         shift_q  <= shift_n;
         bit_cnt  <= bit_cnt_n;
         slot     <= slot_n;
         ch_q     <= ch_n;
         strobe_q <= strobe_n;
         err_q    <= err_n;
      end
   end

   always_comb begin
      state_n     = state;
      shift_n     = shift_q;
      bit_cnt_n   = bit_cnt;
      slot_n      = slot;
      ch_n        = ch_q;
      strobe_n    = '0;
      err_n       = 1'b0;
      word_in     = {shift_q[W-2:0], bus.din};
      frame_start = (bit_cnt == '0) && (slot == 2'd0);

      if (bus.en) begin
         unique case (state)
            HUNT: begin
               if (bus.frame_sync) begin
                  shift_n   = word_in;
                  bit_cnt_n = CW'(1);
                  slot_n    = 2'd0;
                  state_n   = LOCK;
               end
            end
            LOCK: begin
               // A sync seen mid-frame drops the partial slot and restarts at slot 0.
               if (bus.frame_sync && !frame_start) begin
                  err_n     = 1'b1;
                  shift_n   = word_in;
                  bit_cnt_n = CW'(1);
                  slot_n    = 2'd0;
               end else if (!bus.frame_sync && frame_start) begin
                  err_n   = 1'b1;
                  state_n = HUNT;
               end else begin
                  shift_n = word_in;
                  if (bit_cnt == CW'(W - 1)) begin
                     ch_n[slot]     = word_in;
                     strobe_n[slot] = 1'b1;
                     bit_cnt_n      = '0;
                     slot_n         = slot + 2'd1;
                  end else begin
                     bit_cnt_n = bit_cnt + CW'(1);
                  end
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   assign bus.a        = ch_q[0];
   assign bus.b        = ch_q[1];
   assign bus.c        = ch_q[2];
   assign bus.d        = ch_q[3];
   assign bus.va       = strobe_q[0];
   assign bus.vb       = strobe_q[1];
   assign bus.vc       = strobe_q[2];
   assign bus.vd       = strobe_q[3];
   assign bus.s        = slot;
   assign bus.locked   = (state == LOCK);
   assign bus.sync_err = err_q;
endmodule

// File: tb/tb_one_four_tdm_demux.sv
// Bench for one_four_tdm_demux: directed frames plus randomized streams,
// every cycle compared against a frame-position reference model.
module tb_one_four_tdm_demux;
   localparam int W  = 8;
   localparam int VW = 4 * W + 8;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   one_four_tdm_demux_if #(.W(W)) bus ();

   one_four_tdm_demux #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: position within the frame and accumulated slot value.
   bit          m_locked;
   int          m_pos;
   int unsigned m_acc;
   int unsigned m_word [4];
   int          m_strobe;
   bit          m_err;

   function automatic void model_reset();
      m_locked = 0;
      m_pos    = 0;
      m_acc    = 0;
      m_strobe = -1;
      m_err    = 0;
      for (int i = 0; i < 4; i++) m_word[i] = 0;
   endfunction

   function automatic void model_step(bit en, bit din, bit fs);
      m_err    = 0;
      m_strobe = -1;
      if (!en) return;
      if (!m_locked) begin
         if (fs) begin
            m_locked = 1;
            m_pos    = 1;
            m_acc    = din;
         end
      end else if (m_pos == 0 && !fs) begin
         m_err    = 1;
         m_locked = 0;
      end else if (fs && m_pos != 0) begin
         m_err = 1;
         m_pos = 1;
         m_acc = din;
      end else begin
         m_acc = (m_acc * 2 + din) % (1 << W);
         m_pos++;
         if (m_pos % W == 0) begin
            m_strobe         = m_pos / W - 1;
            m_word[m_strobe] = m_acc;
         end
         m_pos = m_pos % (4 * W);
      end
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [1:0] es;
      es = m_locked ? 2'((m_pos / W) % 4) : 2'd0;
      return {W'(m_word[0]), W'(m_word[1]), W'(m_word[2]), W'(m_word[3]),
              m_strobe == 0, m_strobe == 1, m_strobe == 2, m_strobe == 3,
              es, m_locked, m_err};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {bus.a, bus.b, bus.c, bus.d, bus.va, bus.vb, bus.vc, bus.vd,
              bus.s, bus.locked, bus.sync_err};
   endfunction

   task automatic send_bit(input bit en, input bit din, input bit fs);
      bus.en         = en;
      bus.din        = din;
      bus.frame_sync = fs;
      @(posedge clk);
      if (rst) model_reset();
      else     model_step(en, din, fs);
      #1;
   endtask

   task automatic test_reset();
      logic [VW-1:0] o, e;
      bus.en = 0; bus.din = 0; bus.frame_sync = 0;
      model_reset();
      rst = 0;
      #1 rst = 1;
      #1;
      o = obs_vec(); e = exp_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_async: got %h want %h", o, e); end
      repeat (2) send_bit(1, 1, 1);
      o = obs_vec(); e = exp_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_held: got %h want %h", o, e); end
      #3 rst = 0;
   endtask

   task automatic test_frame();
      logic [VW-1:0] o, e;
      logic [W-1:0]  wds [4] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
      for (int w = 0; w < 4; w++)
         for (int i = 0; i < W; i++) begin
            send_bit(1, wds[w][W-1-i], (w == 0 && i == 0));
            o = obs_vec(); e = exp_vec(); total++;
            if (o !== e) begin bad++; $display("FAIL frame w%0d b%0d: got %h want %h", w, i, o, e); end
         end
      total++;
      if ({bus.a, bus.b, bus.c, bus.d} !== 32'hA53C0FF0) begin
         bad++; $display("FAIL frame_words: got %h want a53c0ff0", {bus.a, bus.b, bus.c, bus.d});
      end
   endtask

   task automatic test_back_to_back();
      logic [VW-1:0] o, e;
      logic [W-1:0]  wds [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      for (int w = 0; w < 8; w++)
         for (int i = 0; i < W; i++) begin
            send_bit(1, wds[w][W-1-i], (w % 4 == 0 && i == 0));
            o = obs_vec(); e = exp_vec(); total++;
            if (o !== e) begin bad++; $display("FAIL b2b w%0d b%0d: got %h want %h", w, i, o, e); end
         end
      total++;
      if ({bus.a, bus.b, bus.c, bus.d} !== 32'h55667788) begin
         bad++; $display("FAIL b2b_words: got %h want 55667788", {bus.a, bus.b, bus.c, bus.d});
      end
   endtask

   task automatic test_missing_sync();
      logic [VW-1:0] o, e;
      logic [W-1:0]  wds [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int w = 0; w < 4; w++)
         for (int i = 0; i < W; i++) begin
            send_bit(1, wds[w][W-1-i], (w == 0 && i == 0));
            o = obs_vec(); e = exp_vec(); total++;
            if (o !== e) begin bad++; $display("FAIL nosync_frame w%0d b%0d: got %h want %h", w, i, o, e); end
         end
      for (int i = 0; i < 3 * W; i++) begin
         send_bit(1, 1'($urandom), 0);
         o = obs_vec(); e = exp_vec(); total++;
         if (o !== e) begin bad++; $display("FAIL nosync_hunt b%0d: got %h want %h", i, o, e); end
      end
      total++;
      if ({bus.a, bus.b, bus.c, bus.d, bus.locked} !== {32'h11223344, 1'b0}) begin
         bad++; $display("FAIL nosync_hold: got %h want %h", {bus.a, bus.b, bus.c, bus.d, bus.locked}, {32'h11223344, 1'b0});
      end
   endtask

   task automatic test_mid_slot_sync();
      logic [VW-1:0] o, e;
      logic [W-1:0]  pre  [2] = '{8'h5A, 8'hFF};
      logic [W-1:0]  post [4] = '{8'hC3, 8'h96, 8'h69, 8'hE1};
      for (int i = 0; i < W + 3; i++) begin
         send_bit(1, pre[i / W][W-1-(i % W)], (i == 0));
         o = obs_vec(); e = exp_vec(); total++;
         if (o !== e) begin bad++; $display("FAIL midsync_pre b%0d: got %h want %h", i, o, e); end
      end
      for (int w = 0; w < 4; w++)
         for (int i = 0; i < W; i++) begin
            send_bit(1, post[w][W-1-i], (w == 0 && i == 0));
            o = obs_vec(); e = exp_vec(); total++;
            if (o !== e) begin bad++; $display("FAIL midsync_post w%0d b%0d: got %h want %h", w, i, o, e); end
         end
      total++;
      if ({bus.a, bus.b, bus.c, bus.d} !== 32'hC39669E1) begin
         bad++; $display("FAIL midsync_words: got %h want c39669e1", {bus.a, bus.b, bus.c, bus.d});
      end
   endtask

   task automatic test_en_toggle();
      logic [VW-1:0] o, e;
      logic [W-1:0]  wds [4] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
      for (int w = 0; w < 4; w++)
         for (int i = 0; i < W; i++) begin
            send_bit(1, wds[w][W-1-i], (w == 0 && i == 0));
            o = obs_vec(); e = exp_vec(); total++;
            if (o !== e) begin bad++; $display("FAIL entog_on w%0d b%0d: got %h want %h", w, i, o, e); end
            send_bit(0, 1'($urandom), 1'($urandom));
            o = obs_vec(); e = exp_vec(); total++;
            if (o !== e) begin bad++; $display("FAIL entog_off w%0d b%0d: got %h want %h", w, i, o, e); end
         end
      total++;
      if ({bus.a, bus.b, bus.c, bus.d} !== 32'hA53C0FF0) begin
         bad++; $display("FAIL entog_words: got %h want a53c0ff0", {bus.a, bus.b, bus.c, bus.d});
      end
   endtask

   task automatic test_async_reset();
      logic [VW-1:0] o, e;
      logic [W-1:0]  wds [3] = '{8'h12, 8'h34, 8'h56};
      for (int i = 0; i < 2 * W + 4; i++) begin
         send_bit(1, wds[i / W][W-1-(i % W)], (i == 0));
         o = obs_vec(); e = exp_vec(); total++;
         if (o !== e) begin bad++; $display("FAIL arst_pre b%0d: got %h want %h", i, o, e); end
      end
      @(negedge clk);
      #2 rst = 1;
      model_reset();
      #1;
      o = obs_vec(); e = exp_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL arst_noedge: got %h want %h", o, e); end
      send_bit(1, 1, 1);
      #3 rst = 0;
      for (int i = 0; i < 5 * W; i++) begin
         send_bit(1'($urandom_range(0, 3) != 0), 1'($urandom), 0);
         o = obs_vec(); e = exp_vec(); total++;
         if (o !== e) begin bad++; $display("FAIL arst_post b%0d: got %h want %h", i, o, e); end
      end
   endtask

   task automatic test_random();
      logic [VW-1:0] o, e;
      bit fs;
      for (int n = 0; n < 1500; n++) begin
         if (m_locked && m_pos == 0) fs = ($urandom_range(0, 7) != 0);
         else if (!m_locked)         fs = ($urandom_range(0, 9) == 0);
         else                        fs = ($urandom_range(0, 60) == 0);
         send_bit(1'($urandom_range(0, 3) != 0), 1'($urandom), fs);
         o = obs_vec(); e = exp_vec(); total++;
         if (o !== e) begin bad++; $display("FAIL random n%0d: got %h want %h", n, o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_back_to_back();
      test_missing_sync();
      test_mid_slot_sync();
      test_en_toggle();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/one_four_tdm_demux.md
ONE_FOUR_TDM_DEMUX -- requirements
Module: one_four_tdm_demux

Interface
REQ-001 SHALL have parameter W, default 8, bits per channel slot (W >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port en  input  1  bit-enable; din and frame_sync are sampled only on edges where en=1.
REQ-005 SHALL have port din  input  1  serial TDM data, MSB of each slot first.
REQ-006 SHALL have port frame_sync  input  1  marks that the din bit sampled on this edge is bit W-1 (MSB) of slot 0.
REQ-007 SHALL have ports a, b, c, d  output  W each  held channel words for slots 0, 1, 2, 3.
REQ-008 SHALL have ports va, vb, vc, vd  output  1 each  one-cycle strobe: the matching channel word was updated on the previous edge.
REQ-009 SHALL have port s  output  2  slot currently being received (s1 = s[1], s0 = s[0]).
REQ-010 SHALL have port locked  output  1  high while in state LOCK.
REQ-011 SHALL have port sync_err  output  1  one-cycle strobe on a framing error.

Function
REQ-012 SHALL implement two states: HUNT (not aligned) and LOCK (aligned).
REQ-013 SHALL keep a W-bit shift register, a bit counter 0..W-1 and a 2-bit slot counter (s), all registered.
REQ-014 In HUNT, an edge with en=1, frame_sync=0 SHALL change nothing and discard the din bit.
REQ-015 In HUNT, an edge with en=1, frame_sync=1 SHALL shift in din, set bit counter=1, s=0 and enter LOCK.
REQ-016 In LOCK, each edge with en=1 SHALL shift din into the shift register LSB and increment the bit counter.
REQ-017 When the bit counter is W-1 on an en=1 edge, the word {shift[W-2:0], din} SHALL be written to the channel selected by s (0->a, 1->b, 2->c, 3->d) on that edge, with the bit counter wrapping to 0 and s incrementing modulo 4.
REQ-018 The matching strobe va/vb/vc/vd SHALL be high for exactly the one cycle following the write edge; at most one strobe SHALL be high in any cycle.
REQ-019 Channel words SHALL hold their value between writes; the other three channels SHALL be unaffected by a write.
REQ-020 In LOCK, frame_sync=1 on an en=1 edge with bit counter=0 and s=0 SHALL be accepted as a normal frame boundary (no error).
REQ-021 In LOCK, frame_sync=0 on an en=1 edge with bit counter=0 and s=0 (expected sync missing) SHALL pulse sync_err, enter HUNT and discard the din bit; channel words SHALL be retained.
REQ-022 In LOCK, frame_sync=1 at any other position SHALL pulse sync_err, discard the partial slot (no channel write, no strobe), and resynchronise exactly as REQ-015 (staying in LOCK).
REQ-023 An edge with en=0 SHALL hold all state; strobes and sync_err SHALL be low in the following cycle.
REQ-024 locked SHALL be 1 in LOCK and 0 in HUNT; s SHALL read 0 while in HUNT.
REQ-025 Latency from the last bit of a slot sampled to its strobe high SHALL be one clk cycle, with no dependence on en.

Reset
REQ-026 While rst=1, the block SHALL immediately (without waiting for clk) force state=HUNT, a=b=c=d=0, va=vb=vc=vd=0, s=0, locked=0, sync_err=0, shift register and bit counter 0.
REQ-027 A reset asserted mid-slot or mid-frame SHALL discard all partial data; after release the block SHALL require a new frame_sync before any channel write.
REQ-028 The first en=1 edge after rst deasserts SHALL be processed normally.

Verification
REQ-029 W=8, en=1 constant, frame_sync on first bit, stream A5,3C,0F,F0 -> a=A5,b=3C,c=0F,d=F0; va,vb,vc,vd each high one cycle, 8 cycles apart, locked=1 from the cycle after sync.
REQ-030 Two back-to-back frames (11,22,33,44 then 55,66,77,88) with sync on each frame boundary -> second frame overwrites all channels, sync_err stays 0.
REQ-031 Frame 1 sent correctly, frame_sync omitted at next frame start -> sync_err high one cycle, locked=0, a..d still 11,22,33,44, no strobes until the next sync.
REQ-032 frame_sync asserted at bit 3 of slot 1 -> sync_err pulse, b unchanged, no vb, then the following 32 bits land in a,b,c,d starting from that bit.
REQ-033 en toggling 1,0,1,0 through a full frame of A5,3C,0F,F0 -> same channel words as REQ-029, with each strobe one cycle after its last en=1 edge.
REQ-034 rst pulsed asynchronously (between clk edges) midway through slot 2 -> outputs zero without a clk edge; post-reset bits without frame_sync produce no writes.
